fast_seg_arbiter: RTL and testbench
===================================

FAST_SEG_ARBITER -- requirements
Module: fast_seg_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of pixel-lane requesters sharing one fast_segment_test instance.
REQ-002 Parameter SEG_LAT, default 2: cycles from seg_in_valid to seg_out_valid of the shared segment tester.
REQ-003 Parameter TAG_DEPTH, default 4: in-flight tag FIFO depth; must be at least SEG_LAT+1.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse; IDLE->RUN.
REQ-008 flush  in  1  single-cycle pulse; stop granting and drain in-flight work.
REQ-009 req_valid  in  NUM_REQ  per-lane candidate valid.
REQ-010 req_ready  out  NUM_REQ  per-lane accept; one-hot or zero.
REQ-011 req_bright / req_dark  in  16*NUM_REQ each  lane i occupies bits [16i+15:16i].
REQ-012 seg_in_valid  out  1;  seg_bright / seg_dark  out  16 each  drive the tester.
REQ-013 seg_out_valid / seg_is_corner  in  1 each  tester result.
REQ-014 rsp_valid  out  NUM_REQ;  rsp_corner  out  NUM_REQ  per-lane result pulse.
REQ-015 state  out  2  (IDLE=0, RUN=1, DRAIN=2);  flush_done  out  1;  err_orphan  out  1 (sticky).

Function
REQ-016 FSM IDLE: no grants; start -> RUN; flush -> flush_done pulse next cycle, stay IDLE; start and flush together -> flush wins.
REQ-017 FSM RUN: grant per REQ-018; flush -> DRAIN (start ignored).
REQ-018 In RUN with FIFO count < TAG_DEPTH, req_ready SHALL be high for exactly one lane: the first lane with req_valid=1 at or after rr_ptr, searching upward and wrapping NUM_REQ-1 -> 0.
REQ-019 req_ready is combinational from req_valid, rr_ptr, state and count; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-020 On transfer from lane i: rr_ptr <= (i+1) mod NUM_REQ, and lane index i is pushed to the tag FIFO.
REQ-021 On the same transfer, lane i masks are registered onto seg_bright/seg_dark, with seg_in_valid=1 the next cycle for one cycle; otherwise seg_in_valid=0 and the masks hold.
REQ-022 When seg_out_valid=1 with FIFO non-empty, pop tag t; next cycle rsp_valid[t]=1 and rsp_corner[t]=seg_is_corner; all other rsp bits are 0.
REQ-023 Total latency from accept edge to rsp_valid is SEG_LAT+2 cycles (4 at default); throughput is one candidate per cycle.
REQ-024 Push and pop in the same cycle SHALL both occur; count is unchanged. Full-check uses the pre-pop count.
REQ-025 seg_out_valid with FIFO empty SHALL set err_orphan, drop the result and assert no rsp_valid.
REQ-026 FSM DRAIN: no grants; when count==0 and no seg_in_valid is pending, pulse flush_done for one cycle and go to IDLE.
REQ-027 Responses have no backpressure; a requester must sink rsp_valid every cycle.

Reset
REQ-028 On rst: state=IDLE, rr_ptr=0, FIFO empty, and all of req_ready, seg_in_valid, seg_bright, seg_dark, rsp_valid, rsp_corner, flush_done and err_orphan are 0.
REQ-029 Reset mid-operation discards in-flight tags; the tester shares rst, so no stale result may follow.

Verification
REQ-030 Single lane: start; lane 2 presents bright=0xFF80 -> req_ready=0100 the same cycle; rsp_valid[2]=1 and rsp_corner[2]=1 four cycles after accept.
REQ-031 All four lanes valid continuously from rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; responses return in the same order, one per cycle.
REQ-032 Stall the tester so count reaches TAG_DEPTH -> req_ready=0 until a pop; no tag lost or reordered.
REQ-033 Flush with 3 in flight -> no new grants; flush_done after the last rsp_valid; state returns to 0.
REQ-034 seg_out_valid forced with FIFO empty -> err_orphan=1, rsp_valid=0; rst clears err_orphan.
REQ-035 Assert rst while 2 requests are in flight -> all outputs 0 and state=IDLE; after a new start, the next grant goes to lane 0.

Source files
------------

// File: rtl/fast_seg_arbiter.sv
// fast_seg_arbiter: round-robin front end that lets NUM_REQ pixel lanes share
// one fast segment tester.
//
// Each cycle in RUN, at most one lane is granted (req_ready one-hot). The lane's
// masks are registered towards the tester. The lane index is queued in an
// in-order tag FIFO. Tester results pop the FIFO and are steered back to the
// owning lane as a single-cycle rsp_valid/rsp_corner pulse.
//
// Ports
//   clk, rst                   clock, async active-high reset
//   start, flush               control pulses (IDLE->RUN, stop+drain)
//   req_valid/req_ready        per-lane handshake (ready is combinational)
//   req_bright/req_dark        16-bit masks per lane, lane i at [16i+15:16i]
//   seg_in_valid, seg_bright,  registered request to the shared tester
//   seg_dark
//   seg_out_valid,             tester result, in issue order
//   seg_is_corner
//   rsp_valid/rsp_corner       per-lane result pulse, no backpressure
//   state                      0=IDLE 1=RUN 2=DRAIN
//   flush_done                 single-cycle pulse when a flush has finished
//   err_orphan                 sticky: a tester result arrived with no tag
module fast_seg_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEG_LAT   = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   flush,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_bright,
    input  logic [16*NUM_REQ-1:0]  req_dark,
    output logic                   seg_in_valid,
    output logic [15:0]            seg_bright,
    output logic [15:0]            seg_dark,
    input  logic                   seg_out_valid,
    input  logic                   seg_is_corner,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [NUM_REQ-1:0]     rsp_corner,
    output logic [1:0]             state,
    output logic                   flush_done,
    output logic                   err_orphan
);

    localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);

    localparam logic [LANE_W:0]   NREQ      = (LANE_W+1)'(NUM_REQ);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(TAG_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(TAG_DEPTH - 1);

    // The FIFO must cover every tag the tester can hold plus the one being issued.
    if (TAG_DEPTH < SEG_LAT + 1) begin : g_bad_depth
        $error("fast_seg_arbiter: TAG_DEPTH must be at least SEG_LAT+1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e               state_q;
    logic [LANE_W-1:0]    rr_ptr_q;
    logic [LANE_W-1:0]    tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 seg_in_valid_q;
    logic [15:0]          seg_bright_q, seg_dark_q;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_corner_q;
    logic                 flush_done_q, err_orphan_q;

    logic [LANE_W:0]      scan;
    logic [LANE_W-1:0]    gnt_idx;
    logic                 gnt_any;
    logic                 push, pop, orphan;

    // Round-robin pick. Scanning from the farthest offset down to rr_ptr means
    // the last hit is the nearest valid lane at or after rr_ptr.
    always_comb begin
        scan      = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        req_ready = '0;
        if (state_q == S_RUN && count_q < DEPTH) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan = {1'b0, rr_ptr_q} + (LANE_W+1)'(k);
                if (scan >= NREQ) scan = scan - NREQ;
                if (req_valid[scan[LANE_W-1:0]]) begin
                    gnt_idx = scan[LANE_W-1:0];
                    gnt_any = 1'b1;
                end
            end
            if (gnt_any) req_ready[gnt_idx] = 1'b1;
        end
    end

    assign push   = gnt_any;
    assign pop    = seg_out_valid && (count_q != '0);
    assign orphan = seg_out_valid && (count_q == '0);

    // Tag storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            seg_in_valid_q <= 1'b0;
            seg_bright_q   <= '0;
            seg_dark_q     <= '0;
            rsp_valid_q    <= '0;
            rsp_corner_q   <= '0;
            flush_done_q   <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush)      flush_done_q <= 1'b1;
                    else if (start) state_q      <= S_RUN;
                end
                S_RUN: begin
                    if (flush) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (count_q == '0 && !seg_in_valid_q) begin
                        flush_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (push) begin
                rr_ptr_q     <= (gnt_idx == LAST_LANE) ? '0 : gnt_idx + LANE_W'(1);
                wr_ptr_q     <= (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PTR_W'(1);
                seg_bright_q <= req_bright[{gnt_idx, 4'b0} +: 16];
                seg_dark_q   <= req_dark[{gnt_idx, 4'b0} +: 16];
            end
            seg_in_valid_q <= push;

            if (pop) rd_ptr_q <= (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PTR_W'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            rsp_valid_q  <= '0;
            rsp_corner_q <= '0;
            if (pop) begin
                rsp_valid_q[tag_mem_q[rd_ptr_q]]  <= 1'b1;
                rsp_corner_q[tag_mem_q[rd_ptr_q]] <= seg_is_corner;
            end

            if (orphan) err_orphan_q <= 1'b1;
        end
    end

    assign state        = state_q;
    assign seg_in_valid = seg_in_valid_q;
    assign seg_bright   = seg_bright_q;
    assign seg_dark     = seg_dark_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_corner   = rsp_corner_q;
    assign flush_done   = flush_done_q;
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_fast_seg_arbiter.sv
// Directed bench for fast_seg_arbiter. A small behavioural tester stands in for
// the shared segment unit: two-cycle latency, in-order, corner = bright[15],
// with a stall input that holds results back and a force input for stray results.
module tb_fast_seg_arbiter;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [16*N-1:0]  req_bright, req_dark;
    logic             seg_in_valid;
    logic [15:0]      seg_bright, seg_dark;
    logic             seg_out_valid, seg_is_corner;
    logic [N-1:0]     rsp_valid, rsp_corner;
    logic [1:0]       state;
    logic             flush_done, err_orphan;

    logic             stall = 1'b0;
    logic             force_ov = 1'b0;
    logic             sov_q = 1'b0;
    logic             cor_q = 1'b0;
    bit               bq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Lane corners under the stand-in tester: lane0=1, lane1=0, lane2=1, lane3=0.
    assign req_bright = {16'h7FFF, 16'hFF80, 16'h0001, 16'h8001};
    assign req_dark   = {16'h0044, 16'h0033, 16'h0022, 16'h0011};

    always #5 clk = ~clk;

    fast_seg_arbiter #(.NUM_REQ(N), .SEG_LAT(2), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bright(req_bright), .req_dark(req_dark),
        .seg_in_valid(seg_in_valid), .seg_bright(seg_bright), .seg_dark(seg_dark),
        .seg_out_valid(seg_out_valid), .seg_is_corner(seg_is_corner),
        .rsp_valid(rsp_valid), .rsp_corner(rsp_corner),
        .state(state), .flush_done(flush_done), .err_orphan(err_orphan)
    );

    // Stand-in tester: pop before push gives exactly two cycles of latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bq.delete();
            sov_q <= 1'b0;
            cor_q <= 1'b0;
        end else begin
            if (!stall && bq.size() > 0) begin
                sov_q <= 1'b1;
                cor_q <= bq.pop_front();
            end else begin
                sov_q <= 1'b0;
                cor_q <= 1'b0;
            end
            if (seg_in_valid) bq.push_back(seg_bright[15]);
        end
    end
    assign seg_out_valid = sov_q | force_ov;
    assign seg_is_corner = cor_q;

    localparam logic [3:0] F = 4'hF;
    localparam logic [3:0] B_RDY [10] = '{4'h1,4'h2,4'h4,4'h8,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0};
    localparam logic [3:0] B_RSV [10] = '{4'h0,4'h0,4'h0,4'h0,4'h1,4'h2,4'h4,4'h8,4'h1,4'h0};
    localparam logic [3:0] B_RSC [10] = '{4'h0,4'h0,4'h0,4'h0,4'h1,4'h0,4'h4,4'h0,4'h1,4'h0};
    localparam logic [3:0] C_RDY [15] = '{4'h2,4'h4,4'h8,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h2,4'h0,4'h0,4'h0,4'h0,4'h0};
    localparam logic [3:0] C_RSV [15] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h2,4'h4,4'h8,4'h1,4'h2,4'h0};
    localparam logic [3:0] C_RSC [15] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h4,4'h0,4'h1,4'h0,4'h0};
    localparam logic [3:0] D_VLD [12] = '{F,F,F,4'h0,F,F,F,F,F,4'h0,4'h0,4'h0};
    localparam logic [3:0] D_RDY [12] = '{4'h4,4'h8,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0};
    localparam logic [3:0] D_RSV [12] = '{4'h0,4'h0,4'h0,4'h0,4'h4,4'h8,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0};
    localparam logic [3:0] D_RSC [12] = '{4'h0,4'h0,4'h0,4'h0,4'h4,4'h0,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0};
    localparam logic [1:0] D_ST  [12] = '{2'd1,2'd1,2'd1,2'd1,2'd2,2'd2,2'd2,2'd0,2'd0,2'd0,2'd0,2'd0};
    localparam logic       D_FD  [12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Assert reset mid-cycle and check every output goes to zero immediately.
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; start = 1'b0; flush = 1'b0; req_valid = '0;
        force_ov = 1'b0; stall = 1'b0;
        #1;
        chk("rst_state",      16'(state),        16'h0);
        chk("rst_ready",      16'(req_ready),    16'h0);
        chk("rst_seg_valid",  16'(seg_in_valid), 16'h0);
        chk("rst_seg_bright", seg_bright,        16'h0);
        chk("rst_seg_dark",   seg_dark,          16'h0);
        chk("rst_rsp_valid",  16'(rsp_valid),    16'h0);
        chk("rst_rsp_corner", 16'(rsp_corner),   16'h0);
        chk("rst_flush_done", 16'(flush_done),   16'h0);
        chk("rst_err_orphan", 16'(err_orphan),   16'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle start pulse; the following negedge is the first RUN cycle.
    task automatic go;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single lane 2 request, four-cycle round trip.
        @(negedge clk);
        req_valid = 4'b0100;
        #1 chk("idle_no_grant", 16'(req_ready), 16'h0);
        go();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b0100 : 4'b0000;
            #1;
            chk("a_ready", 16'(req_ready), (c == 0) ? 16'h4 : 16'h0);
            chk("a_rsp_valid", 16'(rsp_valid), (c == 4) ? 16'h4 : 16'h0);
            chk("a_rsp_corner", 16'(rsp_corner), (c == 4) ? 16'h4 : 16'h0);
            if (c == 1) begin
                chk("a_seg_valid", 16'(seg_in_valid), 16'h1);
                chk("a_seg_bright", seg_bright, 16'hFF80);
                chk("a_seg_dark", seg_dark, 16'h0033);
            end
            if (c == 2) begin
                chk("a_seg_valid_off", 16'(seg_in_valid), 16'h0);
                chk("a_seg_hold", seg_bright, 16'hFF80);
            end
        end

        // All lanes valid from rr_ptr=0: back-to-back grants and responses.
        do_reset();
        go();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 5) ? F : 4'h0;
            #1;
            chk("b_ready", 16'(req_ready), 16'(B_RDY[c]));
            chk("b_rsp_valid", 16'(rsp_valid), 16'(B_RSV[c]));
            chk("b_rsp_corner", 16'(rsp_corner), 16'(B_RSC[c]));
            if (c == 1) chk("b_seg_bright0", seg_bright, 16'h8001);
            if (c == 2) chk("b_seg_bright1", seg_bright, 16'h0001);
        end

        // Tester stalled: FIFO fills, grants stop until the first pop.
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            stall     = (c < 7);
            req_valid = (c < 10) ? F : 4'h0;
            #1;
            chk("c_ready", 16'(req_ready), 16'(C_RDY[c]));
            chk("c_rsp_valid", 16'(rsp_valid), 16'(C_RSV[c]));
            chk("c_rsp_corner", 16'(rsp_corner), 16'(C_RSC[c]));
        end

        // Flush with three in flight, then start+flush together in IDLE.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = D_VLD[c];
            flush     = (c == 3 || c == 9);
            start     = (c == 9);
            #1;
            chk("d_ready", 16'(req_ready), 16'(D_RDY[c]));
            chk("d_rsp_valid", 16'(rsp_valid), 16'(D_RSV[c]));
            chk("d_rsp_corner", 16'(rsp_corner), 16'(D_RSC[c]));
            chk("d_state", 16'(state), 16'(D_ST[c]));
            chk("d_flush_done", 16'(flush_done), 16'(D_FD[c]));
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;

        // Stray tester result with an empty FIFO.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            force_ov = (c == 0);
            #1;
            chk("e_err_orphan", 16'(err_orphan), (c == 0) ? 16'h0 : 16'h1);
            chk("e_rsp_valid", 16'(rsp_valid), 16'h0);
        end
        do_reset();

        // Reset with two requests in flight; nothing stale may come back.
        go();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = 4'b1100;
            #1 chk("f_ready", 16'(req_ready), (c == 0) ? 16'h4 : 16'h8);
        end
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("f_no_stale_rsp", 16'(rsp_valid), 16'h0);
            chk("f_state_idle", 16'(state), 16'h0);
        end
        go();
        @(negedge clk);
        req_valid = F;
        #1 chk("f_first_grant_lane0", 16'(req_ready), 16'h1);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
